nand_target_model: RTL and testbench

- Synthesizable responder for the NAND bus driven by the team's NAND controller. Used for FPGA loopback and bench checks of UART2NAND with no real flash fitted.
- Decodes command and address latch cycles: READ (00h + 5 address + 30h), READ ID (90h + 1 address), RESET (FFh).
- Models busy time on r_b and serves deterministic page data on RE strobes.
- Sits on the controller's NAND pins in the same clk domain.

---
 rtl/nand_target_model.sv | 255 +++++++++++++++++++++++++
 tb/tb_nand_target_model.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/nand_target_model.sv
`default_nettype none
// ============================================================================
// nand_target_model : NAND bus responder for READ / READ ID / RESET with busy
//                     timing on r_b and synthetic page data. Revision: 1.0
// ============================================================================
module nand_target_model #(
  parameter int         T_R_CYCLES   = 64,
  parameter int         T_RST_CYCLES = 16,
  parameter int         PAGE_BYTES   = 2112,
  parameter logic [7:0] ID_MAKER     = 8'hEC,
  parameter logic [7:0] ID_DEVICE    = 8'hDA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        cle,
  input  logic        ale,
  input  logic        we,
  input  logic        re,
  input  logic [7:0]  io_in,
  output logic [7:0]  io_out,
  output logic        io_oe,
  output logic        r_b,
  output logic        cmd_err,
  output logic [23:0] row_addr
);

  localparam int MAX_T = (T_R_CYCLES > T_RST_CYCLES) ? T_R_CYCLES : T_RST_CYCLES;
  localparam int CNT_W = (MAX_T < 1) ? 1 : $clog2(MAX_T + 1);
  localparam logic [CNT_W-1:0] C_T_R      = CNT_W'(T_R_CYCLES);
  localparam logic [CNT_W-1:0] C_T_RST    = CNT_W'(T_RST_CYCLES);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
  localparam logic [15:0]      C_PAGE_END = 16'(PAGE_BYTES);
  localparam logic [7:0] C_CMD_READ    = 8'h00;
  localparam logic [7:0] C_CMD_CONFIRM = 8'h30;
  localparam logic [7:0] C_CMD_ID      = 8'h90;
  localparam logic [7:0] C_CMD_RESET   = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADDR     = 3'd1,
    S_ID_ADDR  = 3'd2,
    S_BUSY     = 3'd3,
    S_RST_BUSY = 3'd4,
    S_DATA_OUT = 3'd5,
    S_ID_OUT   = 3'd6
  } state_t;

  state_t           state;
  logic             we_q;
  logic             re_q;
  logic [2:0]       addr_cnt;
  logic [15:0]      col_lat;
  logic [23:0]      row_lat;
  logic [15:0]      column;
  logic [1:0]       id_idx;
  logic [CNT_W-1:0] busy_cnt;

  logic we_edge;
  logic re_edge;
  logic cmd_latch;
  logic addr_latch;
  logic both_latch;

  assign we_edge    = ~we_q & we & ~ce;
  assign re_edge    = ~re_q & re & ~ce;
  assign cmd_latch  = we_edge &  cle & ~ale;
  assign addr_latch = we_edge & ~cle &  ale;
  assign both_latch = we_edge &  cle &  ale;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      we_q     <= 1'b1;
      re_q     <= 1'b1;
      r_b      <= 1'b1;
      cmd_err  <= 1'b0;
      row_addr <= 24'h0;
      addr_cnt <= 3'd0;
      col_lat  <= 16'h0;
      row_lat  <= 24'h0;
      column   <= 16'h0;
      id_idx   <= 2'd0;
      busy_cnt <= '0;
    end else begin
      we_q    <= we;
      re_q    <= re;
      // A latch with both CLE and ALE high only flags an error.
      cmd_err <= both_latch;
      case (state)
        S_IDLE: begin
          if (cmd_latch) begin
            case (io_in)
              C_CMD_READ: begin
                state    <= S_ADDR;
                addr_cnt <= 3'd0;
              end
              C_CMD_ID:    state <= S_ID_ADDR;
              C_CMD_RESET: begin
                state    <= S_RST_BUSY;
                r_b      <= 1'b0;
                busy_cnt <= C_T_RST;
              end
              default:     cmd_err <= 1'b1;
            endcase
          end else if (addr_latch) begin
            cmd_err <= 1'b1;
          end
        end

        S_ADDR: begin
          if (addr_latch) begin
            if (addr_cnt < 3'd5) begin
              case (addr_cnt)
                3'd0:    col_lat[7:0]   <= io_in;
                3'd1:    col_lat[15:8]  <= io_in;
                3'd2:    row_lat[7:0]   <= io_in;
                3'd3:    row_lat[15:8]  <= io_in;
                default: row_lat[23:16] <= io_in;
              endcase
              addr_cnt <= addr_cnt + 3'd1;
            end else begin
              cmd_err <= 1'b1;
            end
          end else if (cmd_latch) begin
            case (io_in)
              C_CMD_CONFIRM: begin
                if (addr_cnt == 3'd5) begin
                  state    <= S_BUSY;
                  r_b      <= 1'b0;
                  busy_cnt <= C_T_R;
                end else begin
                  state   <= S_IDLE;
                  cmd_err <= 1'b1;
                end
              end
              C_CMD_RESET: begin
                state    <= S_RST_BUSY;
                r_b      <= 1'b0;
                busy_cnt <= C_T_RST;
              end
              default: begin
                state   <= S_IDLE;
                cmd_err <= 1'b1;
              end
            endcase
          end
        end

        S_ID_ADDR: begin
          if (addr_latch) begin
            if (io_in == 8'h00) begin
              state  <= S_ID_OUT;
              id_idx <= 2'd0;
            end else begin
              state   <= S_IDLE;
              cmd_err <= 1'b1;
            end
          end else if (cmd_latch) begin
            if (io_in == C_CMD_RESET) begin
              state    <= S_RST_BUSY;
              r_b      <= 1'b0;
              busy_cnt <= C_T_RST;
            end else begin
              state   <= S_IDLE;
              cmd_err <= 1'b1;
            end
          end
        end

        S_BUSY: begin
          if (cmd_latch && io_in == C_CMD_RESET) begin
            state    <= S_RST_BUSY;
            busy_cnt <= C_T_RST;
          end else begin
            if (cmd_latch || addr_latch) cmd_err <= 1'b1;
            // Finishing on the edge where the count would reach zero keeps
            // r_b low for exactly T_R_CYCLES cycles.
            if (busy_cnt <= C_CNT_ONE) begin
              state    <= S_DATA_OUT;
              r_b      <= 1'b1;
              row_addr <= row_lat;
              column   <= col_lat;
            end else begin
              busy_cnt <= busy_cnt - C_CNT_ONE;
            end
          end
        end

        S_RST_BUSY: begin
          if (cmd_latch && io_in == C_CMD_RESET) begin
            busy_cnt <= C_T_RST;
          end else begin
            if (cmd_latch || addr_latch) cmd_err <= 1'b1;
            if (busy_cnt <= C_CNT_ONE) begin
              state <= S_IDLE;
              r_b   <= 1'b1;
            end else begin
              busy_cnt <= busy_cnt - C_CNT_ONE;
            end
          end
        end

        S_DATA_OUT, S_ID_OUT: begin
          if (ce) begin
            state <= S_IDLE;
          end else if (cmd_latch) begin
            case (io_in)
              C_CMD_READ: begin
                state    <= S_ADDR;
                addr_cnt <= 3'd0;
              end
              C_CMD_ID:    state <= S_ID_ADDR;
              C_CMD_RESET: begin
                state    <= S_RST_BUSY;
                r_b      <= 1'b0;
                busy_cnt <= C_T_RST;
              end
              default:     cmd_err <= 1'b1;
            endcase
          end else if (addr_latch) begin
            cmd_err <= 1'b1;
          end else if (re_edge) begin
            if (state == S_DATA_OUT) begin
              if (column < C_PAGE_END) column <= column + 16'd1;
            end else if (id_idx < 2'd2) begin
              id_idx <= id_idx + 2'd1;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    io_out = 8'h00;
    case (state)
      S_DATA_OUT: io_out = (column < C_PAGE_END) ? (column[7:0] ^ row_addr[7:0]) : 8'hFF;
      S_ID_OUT: begin
        case (id_idx)
          2'd0:    io_out = ID_MAKER;
          2'd1:    io_out = ID_DEVICE;
          default: io_out = 8'h00;
        endcase
      end
      default: io_out = 8'h00;
    endcase
  end

  assign io_oe = ((state == S_DATA_OUT) || (state == S_ID_OUT)) && !ce && !re;

endmodule
`default_nettype wire

// File: tb/tb_nand_target_model.sv
`default_nettype none
// ============================================================================
// tb_nand_target_model : directed bench for nand_target_model. Revision: 1.0
// ============================================================================
module tb_nand_target_model;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce  = 1'b1;
  logic        cle = 1'b0;
  logic        ale = 1'b0;
  logic        we  = 1'b1;
  logic        re  = 1'b1;
  logic [7:0]  io_in = 8'h00;
  logic [7:0]  io_out;
  logic        io_oe;
  logic        r_b;
  logic        cmd_err;
  logic [23:0] row_addr;

  int n_checks = 0;
  int n_fail   = 0;

  nand_target_model dut (
    .clk      (clk),
    .rst      (rst),
    .ce       (ce),
    .cle      (cle),
    .ale      (ale),
    .we       (we),
    .re       (re),
    .io_in    (io_in),
    .io_out   (io_out),
    .io_oe    (io_oe),
    .r_b      (r_b),
    .cmd_err  (cmd_err),
    .row_addr (row_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns one cycle after the WE rising edge has been seen by the DUT.
  task automatic bus_write(input logic c, input logic a, input logic [7:0] d);
    cle = c; ale = a; io_in = d; we = 1'b0;
    tick();
    we = 1'b1;
    tick();
    cle = 1'b0; ale = 1'b0;
  endtask

  task automatic send_read(input logic [15:0] col, input logic [23:0] row);
    bus_write(1'b1, 1'b0, 8'h00);
    bus_write(1'b0, 1'b1, col[7:0]);
    bus_write(1'b0, 1'b1, col[15:8]);
    bus_write(1'b0, 1'b1, row[7:0]);
    bus_write(1'b0, 1'b1, row[15:8]);
    bus_write(1'b0, 1'b1, row[23:16]);
    bus_write(1'b1, 1'b0, 8'h30);
  endtask

  task automatic read_byte(output logic [7:0] data, output logic oe_low, output logic oe_high);
    re = 1'b0;
    #1;
    data   = io_out;
    oe_low = io_oe;
    tick();
    re = 1'b1;
    tick();
    oe_high = io_oe;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!r_b && n < 200) begin
      tick();
      n++;
    end
  endtask

  logic [7:0] d;
  logic       ol, oh;
  int         n;
  logic [7:0] exp_bytes [4];

  initial begin
    // Reset
    repeat (3) tick();
    check("rst_io_out", io_out, 8'h00);
    check("rst_io_oe", io_oe, 1'b0);
    check("rst_r_b", r_b, 1'b1);
    check("rst_cmd_err", cmd_err, 1'b0);
    check("rst_row_addr", row_addr, 24'h0);
    rst = 1'b0;
    ce  = 1'b0;
    tick();

    // Page read col 5, row 12h: bytes are col ^ 12h
    send_read(16'h0005, 24'h000012);
    check("rd_rb_fall", r_b, 1'b0);
    wait_ready(n);
    check("rd_busy_len", n, 64);
    check("rd_row_addr", row_addr, 24'h000012);
    exp_bytes[0] = 8'h17; exp_bytes[1] = 8'h14; exp_bytes[2] = 8'h15;
    for (int i = 0; i < 3; i++) begin
      read_byte(d, ol, oh);
      check($sformatf("rd_byte%0d", i), d, exp_bytes[i]);
      check($sformatf("rd_oe_low%0d", i), ol, 1'b1);
      check($sformatf("rd_oe_high%0d", i), oh, 1'b0);
    end

    // READ ID
    bus_write(1'b1, 1'b0, 8'h90);
    bus_write(1'b0, 1'b1, 8'h00);
    exp_bytes[0] = 8'hEC; exp_bytes[1] = 8'hDA; exp_bytes[2] = 8'h00;
    for (int i = 0; i < 3; i++) begin
      read_byte(d, ol, oh);
      check($sformatf("id_byte%0d", i), d, exp_bytes[i]);
      check($sformatf("id_oe_low%0d", i), ol, 1'b1);
      check($sformatf("id_oe_high%0d", i), oh, 1'b0);
    end

    // Short address then confirm
    bus_write(1'b1, 1'b0, 8'h00);
    bus_write(1'b0, 1'b1, 8'h01);
    bus_write(1'b0, 1'b1, 8'h02);
    bus_write(1'b1, 1'b0, 8'h30);
    check("short_cmd_err", cmd_err, 1'b1);
    check("short_rb", r_b, 1'b1);
    tick();
    check("short_cmd_err_clr", cmd_err, 1'b0);
    repeat (3) tick();
    check("short_rb_hold", r_b, 1'b1);
    read_byte(d, ol, oh);
    check("short_oe_idle", ol, 1'b0);

    // Reset command aborts a busy read
    send_read(16'h0000, 24'h000077);
    repeat (18) tick();
    check("abort_rb_pre", r_b, 1'b0);
    bus_write(1'b1, 1'b0, 8'hFF);
    check("abort_rb_post", r_b, 1'b0);
    wait_ready(n);
    check("abort_rst_len", n, 16);
    check("abort_row_kept", row_addr, 24'h000012);
    read_byte(d, ol, oh);
    check("abort_oe_idle", ol, 1'b0);

    // Column 2110 row 0: end of page then saturation
    send_read(16'd2110, 24'h000000);
    wait_ready(n);
    check("sat_busy_len", n, 64);
    exp_bytes[0] = 8'h3E; exp_bytes[1] = 8'h3F; exp_bytes[2] = 8'hFF; exp_bytes[3] = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      read_byte(d, ol, oh);
      check($sformatf("sat_byte%0d", i), d, exp_bytes[i]);
      check($sformatf("sat_oe_low%0d", i), ol, 1'b1);
    end
    bus_write(1'b1, 1'b1, 8'h90);
    check("both_cmd_err_data", cmd_err, 1'b1);
    read_byte(d, ol, oh);
    check("both_still_data", d, 8'hFF);
    check("both_still_oe", ol, 1'b1);

    // Complete a read of row 21h so the reset below has something to clear
    send_read(16'h0000, 24'h000021);
    wait_ready(n);
    read_byte(d, ol, oh);
    check("r21_byte0", d, 8'h21);
    check("r21_row_addr", row_addr, 24'h000021);

    // rst mid-busy
    send_read(16'h0000, 24'h000044);
    repeat (10) tick();
    check("midrst_rb_pre", r_b, 1'b0);
    rst = 1'b1;
    tick();
    check("midrst_rb", r_b, 1'b1);
    check("midrst_row", row_addr, 24'h0);
    check("midrst_cmd_err", cmd_err, 1'b0);
    check("midrst_io_out", io_out, 8'h00);
    re = 1'b0;
    #1;
    check("midrst_oe", io_oe, 1'b0);
    re = 1'b1;
    rst = 1'b0;
    tick();
    bus_write(1'b1, 1'b1, 8'h00);
    check("both_cmd_err_idle", cmd_err, 1'b1);
    tick();
    check("both_cmd_err_clr", cmd_err, 1'b0);
    check("both_rb_idle", r_b, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
